// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - write-back result select, 15-entry register file with bypassed reads, event counters
module wb_regfile #(
  parameter int DATA_W  = 32,
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [DATA_W-1:0]  ReadDataW,
  input  logic [DATA_W-1:0]  ALUOutW,
  input  logic [3:0]         WA3W,
  input  logic               MemToRegW,
  input  logic               RegWriteW,
  input  logic               PCSrcW,
  input  logic [3:0]         RA1D,
  input  logic [3:0]         RA2D,
  input  logic [3:0]         RA3D,
  input  logic [DATA_W-1:0]  PCPlus8D,
  input  logic               count_clr,
  output logic [DATA_W-1:0]  RD1D,
  output logic [DATA_W-1:0]  RD2D,
  output logic [DATA_W-1:0]  RD3D,
  output logic [DATA_W-1:0]  ResultW,
  output logic               PCWriteW,
  output logic [COUNT_W-1:0] retire_count,
  output logic [COUNT_W-1:0] pc_write_count
);

  localparam logic [3:0] PC_IDX = 4'd15;

  logic [DATA_W-1:0] regs [15];
  logic              array_we;

  // Result select, array write enable and PC write strobe.
  // array_we is gated by reset so the bypass never shows a write that
  // the array is about to discard; RegWriteW leads so 0 masks the others.
  always_comb begin
    ResultW  = MemToRegW ? ReadDataW : ALUOutW;
    array_we = RegWriteW && (WA3W != PC_IDX) && !reset;
    PCWriteW = RegWriteW && PCSrcW && (WA3W == PC_IDX);
  end

  // One read port: R15 substitution, then write-through bypass, then array.
  function automatic logic [DATA_W-1:0] read_port(input logic [3:0] ra);
    logic [DATA_W-1:0] data;
    if (ra == PC_IDX) begin
      data = PCPlus8D;
    end else if (array_we && (WA3W == ra)) begin
      data = ResultW;
    end else begin
      data = regs[ra];
    end
    return data;
  endfunction

  // Three independent decode read ports.
  always_comb begin
    RD1D = read_port(RA1D);
    RD2D = read_port(RA2D);
    RD3D = read_port(RA3D);
  end

  // Register array: cleared asynchronously, written on committed edges.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 15; i++) begin
        regs[i] <= '0;
      end
    end else if (array_we) begin
      regs[WA3W] <= ResultW;
    end
  end

  // Event counters: clear wins over increment, arithmetic wraps.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retire_count   <= '0;
      pc_write_count <= '0;
    end else if (count_clr) begin
      retire_count   <= '0;
      pc_write_count <= '0;
    end else begin
      if (array_we) begin
        retire_count <= retire_count + COUNT_W'(1);
      end
      if (PCWriteW) begin
        pc_write_count <= pc_write_count + COUNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
// tb/tb_wb_regfile.sv - scoreboard testbench for wb_regfile
module tb_wb_regfile;

  localparam int DATA_W  = 32;
  localparam int COUNT_W = 16;

  logic               clk;
  logic               reset;
  logic [DATA_W-1:0]  ReadDataW;
  logic [DATA_W-1:0]  ALUOutW;
  logic [3:0]         WA3W;
  logic               MemToRegW;
  logic               RegWriteW;
  logic               PCSrcW;
  logic [3:0]         RA1D;
  logic [3:0]         RA2D;
  logic [3:0]         RA3D;
  logic [DATA_W-1:0]  PCPlus8D;
  logic               count_clr;
  logic [DATA_W-1:0]  RD1D;
  logic [DATA_W-1:0]  RD2D;
  logic [DATA_W-1:0]  RD3D;
  logic [DATA_W-1:0]  ResultW;
  logic               PCWriteW;
  logic [COUNT_W-1:0] retire_count;
  logic [COUNT_W-1:0] pc_write_count;

  int errors = 0;
  int checks = 0;

  logic [DATA_W-1:0] model [15];
  logic [DATA_W-1:0] sb [$];
  logic [DATA_W-1:0] exp_v;

  wb_regfile #(.DATA_W(DATA_W), .COUNT_W(COUNT_W)) dut (
    .clk(clk), .reset(reset),
    .ReadDataW(ReadDataW), .ALUOutW(ALUOutW), .WA3W(WA3W),
    .MemToRegW(MemToRegW), .RegWriteW(RegWriteW), .PCSrcW(PCSrcW),
    .RA1D(RA1D), .RA2D(RA2D), .RA3D(RA3D), .PCPlus8D(PCPlus8D),
    .count_clr(count_clr),
    .RD1D(RD1D), .RD2D(RD2D), .RD3D(RD3D), .ResultW(ResultW),
    .PCWriteW(PCWriteW), .retire_count(retire_count), .pc_write_count(pc_write_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    RegWriteW = 1'b0;
    MemToRegW = 1'b0;
    PCSrcW    = 1'b0;
    count_clr = 1'b0;
  endtask

  task automatic drive_write(input logic [3:0] idx, input logic [DATA_W-1:0] val);
    ALUOutW   = val;
    MemToRegW = 1'b0;
    PCSrcW    = 1'b0;
    WA3W      = idx;
    RegWriteW = 1'b1;
    if (idx != 4'd15) model[idx] = val;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    PCPlus8D = 32'h0000_0108;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    for (int i = 0; i < 16; i++) begin
      RA1D = 4'(i); RA2D = 4'(i); RA3D = 4'(i);
      exp_v = (i == 15) ? 32'h0000_0108 : 32'h0;
      repeat (3) sb.push_back(exp_v);
      #1;
      exp_v = sb.pop_front(); checks++;
      if (RD1D !== exp_v) begin errors++; $display("FAIL reset_rd1 r%0d got %h want %h", i, RD1D, exp_v); end
      exp_v = sb.pop_front(); checks++;
      if (RD2D !== exp_v) begin errors++; $display("FAIL reset_rd2 r%0d got %h want %h", i, RD2D, exp_v); end
      exp_v = sb.pop_front(); checks++;
      if (RD3D !== exp_v) begin errors++; $display("FAIL reset_rd3 r%0d got %h want %h", i, RD3D, exp_v); end
    end
    checks++;
    if (retire_count !== 16'h0 || pc_write_count !== 16'h0) begin
      errors++; $display("FAIL reset_counters got %h/%h want 0/0", retire_count, pc_write_count);
    end
  endtask

  task automatic test_bypass();
    drive_write(4'd3, 32'hDEAD_BEEF);
    RA1D = 4'd3;
    sb.push_back(32'hDEAD_BEEF);
    #1;
    exp_v = sb.pop_front(); checks++;
    if (RD1D !== exp_v) begin errors++; $display("FAIL bypass_pre got %h want %h", RD1D, exp_v); end
    tick();
    RegWriteW = 1'b0;
    sb.push_back(32'hDEAD_BEEF);
    #1;
    exp_v = sb.pop_front(); checks++;
    if (RD1D !== exp_v) begin errors++; $display("FAIL bypass_post got %h want %h", RD1D, exp_v); end
    checks++;
    if (retire_count !== 16'd1) begin errors++; $display("FAIL bypass_retire got %0d want 1", retire_count); end
  endtask

  task automatic test_pc_write();
    ReadDataW = 32'h1234_5678;
    ALUOutW   = 32'h0BAD_0BAD;
    MemToRegW = 1'b1;
    WA3W      = 4'd15;
    RegWriteW = 1'b1;
    PCSrcW    = 1'b1;
    RA1D      = 4'd15;
    RA2D      = 4'd3;
    PCPlus8D  = 32'h0000_0200;
    #1;
    checks++;
    if (ResultW !== 32'h1234_5678) begin errors++; $display("FAIL pc_result got %h want 12345678", ResultW); end
    checks++;
    if (PCWriteW !== 1'b1) begin errors++; $display("FAIL pc_write got %b want 1", PCWriteW); end
    checks++;
    if (RD1D !== 32'h0000_0200) begin errors++; $display("FAIL pc_r15 got %h want 00000200", RD1D); end
    tick();
    idle();
    #1;
    checks++;
    if (retire_count !== 16'd1) begin errors++; $display("FAIL pc_retire got %0d want 1", retire_count); end
    checks++;
    if (pc_write_count !== 16'd1) begin errors++; $display("FAIL pc_count got %0d want 1", pc_write_count); end
    checks++;
    if (RD2D !== 32'hDEAD_BEEF) begin errors++; $display("FAIL pc_r3_kept got %h want deadbeef", RD2D); end
    // X-safety: disabled write with unknown controls must not disturb state
    WA3W = 4'bxxxx; MemToRegW = 1'bx; PCSrcW = 1'bx; RegWriteW = 1'b0;
    tick();
    idle();
    WA3W = 4'd0;
    #1;
    checks++;
    if (retire_count !== 16'd1 || pc_write_count !== 16'd1 || RD2D !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL xsafe got %0d/%0d/%h want 1/1/deadbeef", retire_count, pc_write_count, RD2D);
    end
  endtask

  task automatic test_wrap();
    count_clr = 1'b1;
    tick();
    count_clr = 1'b0;
    for (int i = 0; i < 65535; i++) begin
      drive_write(4'(i % 15), DATA_W'(i) ^ 32'hA500_0000);
      tick();
    end
    RegWriteW = 1'b0;
    #1;
    checks++;
    if (retire_count !== 16'hFFFF) begin errors++; $display("FAIL wrap_full got %h want ffff", retire_count); end
    drive_write(4'd2, 32'hCAFE_0002);
    tick();
    RegWriteW = 1'b0;
    #1;
    checks++;
    if (retire_count !== 16'h0000) begin errors++; $display("FAIL wrap_zero got %h want 0000", retire_count); end
    drive_write(4'd4, 32'h0000_4444);
    count_clr = 1'b1;
    tick();
    idle();
    #1;
    checks++;
    if (retire_count !== 16'h0 || pc_write_count !== 16'h0) begin
      errors++; $display("FAIL clr_override got %h/%h want 0/0", retire_count, pc_write_count);
    end
    for (int i = 0; i < 15; i++) sb.push_back(model[i]);
    for (int i = 0; i < 15; i++) begin
      RA2D = 4'(i);
      #1;
      exp_v = sb.pop_front(); checks++;
      if (RD2D !== exp_v) begin errors++; $display("FAIL wrap_array r%0d got %h want %h", i, RD2D, exp_v); end
    end
  endtask

  task automatic test_async_reset();
    drive_write(4'd5, 32'h0000_000A);
    tick();
    drive_write(4'd5, 32'h0000_000B);
    RA1D = 4'd5;
    #2;
    reset = 1'b1;
    for (int i = 0; i < 15; i++) model[i] = '0;
    sb.push_back(32'h0);
    #1;
    exp_v = sb.pop_front(); checks++;
    if (RD1D !== exp_v) begin errors++; $display("FAIL async_rst_r5 got %h want %h", RD1D, exp_v); end
    checks++;
    if (retire_count !== 16'h0) begin errors++; $display("FAIL async_rst_cnt got %h want 0", retire_count); end
    tick();
    reset = 1'b0;
    RegWriteW = 1'b0;
    tick();
    sb.push_back(32'h0);
    #1;
    exp_v = sb.pop_front(); checks++;
    if (RD1D !== exp_v || retire_count !== 16'h0) begin
      errors++; $display("FAIL async_release got %h/%0d want %h/0", RD1D, retire_count, exp_v);
    end
    drive_write(4'd5, 32'h0000_000C);
    tick();
    RegWriteW = 1'b0;
    sb.push_back(32'h0000_000C);
    #1;
    exp_v = sb.pop_front(); checks++;
    if (RD1D !== exp_v || retire_count !== 16'd1) begin
      errors++; $display("FAIL async_rewrite got %h/%0d want %h/1", RD1D, retire_count, exp_v);
    end
  endtask

  task automatic test_multi_port();
    drive_write(4'd7, 32'h55AA_55AA);
    tick();
    RegWriteW = 1'b0;
    RA1D = 4'd7; RA2D = 4'd7; RA3D = 4'd7;
    repeat (3) sb.push_back(32'h55AA_55AA);
    #1;
    exp_v = sb.pop_front(); checks++;
    if (RD1D !== exp_v) begin errors++; $display("FAIL multi_rd1 got %h want %h", RD1D, exp_v); end
    exp_v = sb.pop_front(); checks++;
    if (RD2D !== exp_v) begin errors++; $display("FAIL multi_rd2 got %h want %h", RD2D, exp_v); end
    exp_v = sb.pop_front(); checks++;
    if (RD3D !== exp_v) begin errors++; $display("FAIL multi_rd3 got %h want %h", RD3D, exp_v); end
    drive_write(4'd7, 32'h0000_0001);
    repeat (3) sb.push_back(32'h0000_0001);
    #1;
    exp_v = sb.pop_front(); checks++;
    if (RD1D !== exp_v) begin errors++; $display("FAIL multi_byp_rd1 got %h want %h", RD1D, exp_v); end
    exp_v = sb.pop_front(); checks++;
    if (RD2D !== exp_v) begin errors++; $display("FAIL multi_byp_rd2 got %h want %h", RD2D, exp_v); end
    exp_v = sb.pop_front(); checks++;
    if (RD3D !== exp_v) begin errors++; $display("FAIL multi_byp_rd3 got %h want %h", RD3D, exp_v); end
    tick();
    idle();
  endtask

  initial begin
    reset = 1'b1;
    ReadDataW = '0; ALUOutW = '0; WA3W = '0;
    RA1D = '0; RA2D = '0; RA3D = '0; PCPlus8D = '0;
    idle();
    for (int i = 0; i < 15; i++) model[i] = '0;
    test_reset();
    test_bypass();
    test_pc_write();
    test_wrap();
    test_async_reset();
    test_multi_port();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
